// File: rtl/alu_exec_if.sv
// Handshake and debug bundle for the two-stage ALU execution pipe.
// master drives instructions, out_ready and dbg_sel; slave is the pipe itself.
interface alu_exec_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [AW-1:0]    in_rd;
  logic [AW-1:0]    in_rs1;
  logic [AW-1:0]    in_rs2;
  logic [WIDTH-1:0] in_imm;
  logic             in_use_imm;
  logic             in_we;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [AW-1:0]    out_rd;
  logic             out_cf;
  logic             out_of;
  logic             out_zf;

  logic [AW-1:0]    dbg_sel;
  logic [WIDTH-1:0] dbg_data;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_use_imm, in_we,
    output out_ready, dbg_sel,
    input  in_ready, out_valid, out_data, out_rd, out_cf, out_of, out_zf, dbg_data
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_use_imm, in_we,
    input  out_ready, dbg_sel,
    output in_ready, out_valid, out_data, out_rd, out_cf, out_of, out_zf, dbg_data
  );
endinterface

// File: rtl/alu_exec_pipe.sv
// Two-stage ALU execution pipe with an internal register file.
// S1 holds captured operands; the ALU works combinationally on S1 and the
// result is written back and loaded into the S2 output register together.
// Optional feature: define ALU_EXEC_FWD_EN to forward the S1 result into a
// dependent instruction being accepted; otherwise such an instruction is
// held off for one cycle until the write-back has landed.
module alu_exec_pipe #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
) (
  input  logic      clk,
  input  logic      rst,
  alu_exec_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int SW = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             cf;
    logic             of;
  } alu_out_t;

  // Opcodes 8..15 are reserved and yield zero with clear flags.
  function automatic alu_out_t alu_calc(input logic [3:0] op,
                                        input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
    alu_out_t           r;
    logic [WIDTH:0]        uw;
    logic signed [WIDTH:0] sw;
    r  = '0;
    uw = '0;
    sw = '0;
    case (op)
      4'd0: begin
        uw    = {1'b0, a} + {1'b0, b};
        sw    = $signed({a[WIDTH-1], a}) + $signed({b[WIDTH-1], b});
        r.res = uw[WIDTH-1:0];
        r.cf  = uw[WIDTH];
        r.of  = sw[WIDTH] ^ sw[WIDTH-1];
      end
      4'd1: begin
        uw    = {1'b0, a} - {1'b0, b};
        sw    = $signed({a[WIDTH-1], a}) - $signed({b[WIDTH-1], b});
        r.res = uw[WIDTH-1:0];
        r.cf  = uw[WIDTH];
        r.of  = sw[WIDTH] ^ sw[WIDTH-1];
      end
      4'd2:    r.res = a & b;
      4'd3:    r.res = a | b;
      4'd4:    r.res = a ^ b;
      4'd5:    r.res = a << b[SW-1:0];
      4'd6:    r.res = a >> b[SW-1:0];
      4'd7:    r.res = b;
      default: r     = '0;
    endcase
    return r;
  endfunction

  logic             vld_p1;
  logic [3:0]       op_p1;
  logic [AW-1:0]    rd_p1;
  logic             we_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;

  logic             vld_p2;
  logic [WIDTH-1:0] data_p2;
  logic [AW-1:0]    rd_p2;
  logic             cf_p2;
  logic             of_p2;
  logic             zf_p2;

  logic [WIDTH-1:0] rf [NREGS];

  alu_out_t         alu_p1;
  logic             adv_p1;
  logic             wr_p1;
  logic             hit_rs1;
  logic             hit_rs2;
  logic             can_take;
  logic             in_fire;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

  // Issue control: S1 advance, write-back qualification, hazard and operand select
  always_comb begin
    alu_p1   = alu_calc(op_p1, a_p1, b_p1);
    adv_p1   = vld_p1 && (!vld_p2 || bus.out_ready);
    wr_p1    = adv_p1 && we_p1 && !op_p1[3];
    hit_rs1  = wr_p1 && (bus.in_rs1 == rd_p1);
    hit_rs2  = wr_p1 && !bus.in_use_imm && (bus.in_rs2 == rd_p1);
    can_take = !rst && (!vld_p1 || adv_p1);
    rs1_val  = rf[bus.in_rs1];
    rs2_val  = rf[bus.in_rs2];
`ifdef ALU_EXEC_FWD_EN
    bus.in_ready = can_take;
    opa = hit_rs1 ? alu_p1.res : rs1_val;
    opb = bus.in_use_imm ? bus.in_imm : (hit_rs2 ? alu_p1.res : rs2_val);
`else
    bus.in_ready = can_take && !(hit_rs1 || hit_rs2);
    opa = rs1_val;
    opb = bus.in_use_imm ? bus.in_imm : rs2_val;
`endif
    in_fire = bus.in_valid && bus.in_ready;
  end

  // Stage occupancy flags; reset discards anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (in_fire)     vld_p1 <= 1'b1;
      else if (adv_p1) vld_p1 <= 1'b0;
      if (adv_p1)             vld_p2 <= 1'b1;
      else if (bus.out_ready) vld_p2 <= 1'b0;
    end
  end

  // ---- S0 -> S1: capture operands of the accepted instruction
  always_ff @(posedge clk) begin
    if (in_fire) begin
      op_p1 <= bus.in_op;
      rd_p1 <= bus.in_rd;
      we_p1 <= bus.in_we;
      a_p1  <= opa;
      b_p1  <= opb;
    end
  end

  // ---- S1 -> S2: result register, holds while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p2 <= '0;
      rd_p2   <= '0;
      cf_p2   <= 1'b0;
      of_p2   <= 1'b0;
      zf_p2   <= 1'b0;
    end else if (adv_p1) begin
      data_p2 <= alu_p1.res;
      rd_p2   <= rd_p1;
      cf_p2   <= alu_p1.cf;
      of_p2   <= alu_p1.of;
      zf_p2   <= (alu_p1.res == '0);
    end
  end

  // Register file write-back, same edge that loads S2
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wr_p1) begin
      rf[rd_p1] <= alu_p1.res;
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.out_data  = data_p2;
  assign bus.out_rd    = rd_p2;
  assign bus.out_cf    = cf_p2;
  assign bus.out_of    = of_p2;
  assign bus.out_zf    = zf_p2;
  assign bus.dbg_data  = rf[bus.dbg_sel];
endmodule

// File: tb/tb_alu_exec_pipe.sv
// Scoreboard bench for alu_exec_pipe (WIDTH=16, NREGS=16).
module tb_alu_exec_pipe;
  localparam int WIDTH = 16;
  localparam int NREGS = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_exec_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  alu_exec_pipe #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  rd;
    logic        cf;
    logic        of;
    logic        zf;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mreg [16];
  int          checks = 0;
  int          errors = 0;
  int          n_out  = 0;
  exp_t        last;
  logic        bp_rand = 1'b0;
  int          low;

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [3:0] rd);
    exp_t        e;
    logic [16:0] t;
    e = '0;
    e.rd = rd;
    case (op)
      4'd0: begin
        t = {1'b0, a} + {1'b0, b};
        e.data = t[15:0];
        e.cf = t[16];
        e.of = (a[15] == b[15]) && (e.data[15] != a[15]);
      end
      4'd1: begin
        e.data = a - b;
        e.cf = (a < b);
        e.of = (a[15] != b[15]) && (e.data[15] != a[15]);
      end
      4'd2: e.data = a & b;
      4'd3: e.data = a | b;
      4'd4: e.data = a ^ b;
      4'd5: e.data = a << b[3:0];
      4'd6: e.data = a >> b[3:0];
      4'd7: e.data = b;
      default: e.data = 16'h0;
    endcase
    e.zf = (e.data == 16'h0);
    return e;
  endfunction

  // Model the instruction at the moment it is accepted (in program order)
  task automatic accept_model();
    exp_t        e;
    logic [15:0] a;
    logic [15:0] b;
    a = mreg[bus.in_rs1];
    b = bus.in_use_imm ? bus.in_imm : mreg[bus.in_rs2];
    e = model(bus.in_op, a, b, bus.in_rd);
    sb.push_back(e);
    if (bus.in_we && bus.in_op < 4'd8) mreg[bus.in_rd] = e.data;
  endtask

  // Output monitor: every completed output transfer is popped and compared
  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      got = {bus.out_data, bus.out_rd, bus.out_cf, bus.out_of, bus.out_zf};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected got=%h (no pending expectation)", got);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL out_txn got data=%h rd=%0d cf=%b of=%b zf=%b exp data=%h rd=%0d cf=%b of=%b zf=%b",
                   got.data, got.rd, got.cf, got.of, got.zf, e.data, e.rd, e.cf, e.of, e.zf);
        end
      end
      last = got;
      n_out++;
    end
  end

  task automatic drive_instr(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                             input logic [3:0] rs2, input logic [15:0] imm,
                             input logic use_imm, input logic we);
    bus.in_op = op;  bus.in_rd = rd;   bus.in_rs1 = rs1; bus.in_rs2 = rs2;
    bus.in_imm = imm; bus.in_use_imm = use_imm; bus.in_we = we;
    bus.in_valid = 1'b1;
  endtask

  task automatic wait_accept(output int low_cycles);
    bit done;
    done = 1'b0;
    low_cycles = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        accept_model();
        done = 1'b1;
      end else begin
        low_cycles++;
      end
      @(posedge clk);
      #1;
      if (done) bus.in_valid = 1'b0;
      if (bp_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready=%b required 1 within 40 cycles", bus.in_ready);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                      input logic [3:0] rs2, input logic [15:0] imm,
                      input logic use_imm, input logic we, output int low_cycles);
    drive_instr(op, rd, rs1, rs2, imm, use_imm, we);
    wait_accept(low_cycles);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 60 && !done; k++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && bus.out_valid === 1'b0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d out_valid=%b required 0 and 0", sb.size(), bus.out_valid);
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.dbg_sel = '0;
    drive_instr(4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got=%b required=0", bus.in_ready);
    end
    checks++;
    if ({bus.out_valid, bus.out_data, bus.out_rd, bus.out_cf, bus.out_of, bus.out_zf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got vld=%b data=%h rd=%0d flags=%b%b%b required all 0",
               bus.out_valid, bus.out_data, bus.out_rd, bus.out_cf, bus.out_of, bus.out_zf);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mreg[i] = '0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_in_ready got=%b required=1", bus.in_ready);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      bus.dbg_sel = 4'(i);
      @(negedge clk);
      if (bus.dbg_data !== 16'h0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL reset_regs got %0d nonzero registers required 0", bad);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    send(4'd7, 4'd1, 4'd0, 4'd0, 16'd15, 1'b1, 1'b1, low);
    send(4'd7, 4'd2, 4'd0, 4'd0, 16'd30, 1'b1, 1'b1, low);
    send(4'd0, 4'd3, 4'd1, 4'd2, 16'd0, 1'b0, 1'b1, low);
    drain();
    checks++;
    if (last !== {16'd45, 4'd3, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL add_basic got data=%0d rd=%0d required data=45 rd=3 flags 000", last.data, last.rd);
    end
    bus.dbg_sel = 4'd3;
    @(negedge clk);
    checks++;
    if (bus.dbg_data !== 16'd45) begin
      errors++; $display("FAIL dbg_r3 got=%0d required=45", bus.dbg_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int exp_low;
`ifdef ALU_EXEC_FWD_EN
    exp_low = 0;
`else
    exp_low = 1;
`endif
    send(4'd7, 4'd1, 4'd0, 4'd0, 16'd5, 1'b1, 1'b1, low);
    send(4'd0, 4'd1, 4'd1, 4'd1, 16'd0, 1'b0, 1'b1, low);
    checks++;
    if (low != exp_low) begin
      errors++; $display("FAIL dep_ready_low got=%0d cycles required=%0d", low, exp_low);
    end
    drain();
    checks++;
    if (last.data !== 16'd10) begin
      errors++; $display("FAIL dep_result got=%0d required=10", last.data);
    end
    bus.dbg_sel = 4'd1;
    @(negedge clk);
    checks++;
    if (bus.dbg_data !== 16'd10) begin
      errors++; $display("FAIL dbg_r1 got=%0d required=10", bus.dbg_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flags();
    send(4'd7, 4'd4, 4'd0, 4'd0, 16'hFFFF, 1'b1, 1'b1, low);
    send(4'd7, 4'd5, 4'd0, 4'd0, 16'h0001, 1'b1, 1'b1, low);
    send(4'd0, 4'd6, 4'd4, 4'd5, 16'h0, 1'b0, 1'b1, low);
    drain();
    checks++;
    if (last !== {16'h0000, 4'd6, 1'b1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL add_carry got data=%h cf=%b of=%b zf=%b required 0000 1 0 1", last.data, last.cf, last.of, last.zf);
    end
    send(4'd7, 4'd7, 4'd0, 4'd0, 16'h7FFF, 1'b1, 1'b1, low);
    send(4'd0, 4'd8, 4'd7, 4'd5, 16'h0, 1'b0, 1'b1, low);
    drain();
    checks++;
    if (last !== {16'h8000, 4'd8, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL add_overflow got data=%h cf=%b of=%b zf=%b required 8000 0 1 0", last.data, last.cf, last.of, last.zf);
    end
    send(4'd7, 4'd9, 4'd0, 4'd0, 16'd3, 1'b1, 1'b1, low);
    send(4'd7, 4'd10, 4'd0, 4'd0, 16'd5, 1'b1, 1'b1, low);
    send(4'd1, 4'd11, 4'd9, 4'd10, 16'h0, 1'b0, 1'b1, low);
    drain();
    checks++;
    if (last !== {16'hFFFE, 4'd11, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sub_borrow got data=%h cf=%b of=%b zf=%b required FFFE 1 0 0", last.data, last.cf, last.of, last.zf);
    end
  endtask

  task automatic test_reserved();
    send(4'd9, 4'd4, 4'd1, 4'd2, 16'h0, 1'b0, 1'b1, low);
    drain();
    checks++;
    if (last !== {16'h0000, 4'd4, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reserved_out got data=%h rd=%0d zf=%b required 0000 4 1", last.data, last.rd, last.zf);
    end
    bus.dbg_sel = 4'd4;
    @(negedge clk);
    checks++;
    if (bus.dbg_data !== 16'hFFFF) begin
      errors++; $display("FAIL reserved_nowrite got=%h required=FFFF", bus.dbg_data);
    end
    @(posedge clk); #1;
    send(4'd0, 4'd5, 4'd1, 4'd2, 16'h0, 1'b0, 1'b0, low);
    drain();
    checks++;
    if (last.data !== 16'd40 || last.rd !== 4'd5) begin
      errors++; $display("FAIL nowe_out got data=%0d rd=%0d required 40 5", last.data, last.rd);
    end
    bus.dbg_sel = 4'd5;
    @(negedge clk);
    checks++;
    if (bus.dbg_data !== 16'd1) begin
      errors++; $display("FAIL nowe_reg got=%h required=0001", bus.dbg_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int bad;
    int n0;
    n0 = n_out;
    bus.out_ready = 1'b0;
    send(4'd7, 4'd12, 4'd0, 4'd0, 16'h0111, 1'b1, 1'b1, low);
    send(4'd7, 4'd13, 4'd0, 4'd0, 16'h0222, 1'b1, 1'b1, low);
    drive_instr(4'd0, 4'd14, 4'd12, 4'd13, 16'h0, 1'b0, 1'b1);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
          bus.out_data !== 16'h0111 || bus.out_rd !== 4'd12) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_hold got %0d bad stall cycles required 0 (last data=%h in_ready=%b)",
                         bad, bus.out_data, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    wait_accept(low);
    drain();
    checks++;
    if (n_out - n0 != 3) begin
      errors++; $display("FAIL bp_count got=%0d outputs required=3", n_out - n0);
    end
    checks++;
    if (last.data !== 16'h0333 || last.rd !== 4'd14) begin
      errors++; $display("FAIL bp_last got data=%h rd=%0d required 0333 14", last.data, last.rd);
    end
  endtask

  task automatic test_random();
    int bad;
    logic [3:0] op;
    bp_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
      send(op, 4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           16'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), low);
    end
    bp_rand = 1'b0;
    drain();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      bus.dbg_sel = 4'(i);
      @(negedge clk);
      if (bus.dbg_data !== mreg[i]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL random_regfile got %0d differing registers required 0", bad);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int bad;
    bus.out_ready = 1'b0;
    send(4'd7, 4'd2, 4'd0, 4'd0, 16'h0055, 1'b1, 1'b1, low);
    send(4'd7, 4'd6, 4'd0, 4'd0, 16'h0066, 1'b1, 1'b1, low);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 16; i++) mreg[i] = '0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0) begin
      errors++; $display("FAIL midrst_out got vld=%b data=%h required 0 0000", bus.out_valid, bus.out_data);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      bus.dbg_sel = 4'(i);
      @(negedge clk);
      if (bus.dbg_data !== 16'h0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL midrst_regs got %0d nonzero registers required 0", bad);
    end
    @(posedge clk); #1;
    send(4'd7, 4'd3, 4'd0, 4'd0, 16'h0077, 1'b1, 1'b1, low);
    drain();
    bus.dbg_sel = 4'd3;
    @(negedge clk);
    checks++;
    if (bus.dbg_data !== 16'h0077) begin
      errors++; $display("FAIL midrst_recover got=%h required=0077", bus.dbg_data);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_flags();
    test_reserved();
    test_backpressure();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1);
  end
endmodule
